// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, reset vector and the fetch packet
// carried from fetch to decode.
package cpu_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h80000000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] dnpc;
    } fetch_pkt_t;
endpackage

// File: rtl/wrap_ptr.sv
// Free-running modulo-2^W pointer with enable; clear takes priority over enable.
module wrap_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       ptr <= '0;
        else if (clr)   ptr <= '0;
        else if (en)    ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/ifu_fetch_queue.sv
// Show-ahead instruction queue between fetch and decode; flush discards all
// buffered packets on a redirect.
module ifu_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_inst,
    input  logic [XLEN-1:0]            in_dnpc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_inst,
    output logic [XLEN-1:0]            out_dnpc,
    output logic [$clog2(DEPTH):0]     count
);
    import cpu_pkg::fetch_pkt_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_pkt_t          mem [DEPTH];
    fetch_pkt_t          head;
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic                push;
    logic                pop;

    // Full/empty come from the occupancy counter, so pointer equality is never ambiguous.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    wrap_ptr #(.W(AW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (push),
        .clr (flush),
        .ptr (wptr)
    );

    wrap_ptr #(.W(AW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (pop),
        .clr (flush),
        .ptr (rptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wptr] <= '{pc: in_pc, inst: in_inst, dnpc: in_dnpc};
        end
    end

    // Head is masked to zero when empty so decode never sees stale data.
    assign head     = mem[rptr];
    assign out_pc   = out_valid ? head.pc   : '0;
    assign out_inst = out_valid ? head.inst : '0;
    assign out_dnpc = out_valid ? head.dnpc : '0;
endmodule
